// File: rtl/ntt_pkg.sv
// Shared NTT constants for q = 2^28 - 2^16 + 1, plus the single-cycle modular add/sub helpers.
package ntt_pkg;
    localparam int DATA_W   = 28;
    localparam int MULT_LAT = 5;
    localparam int TW_DEPTH = 128;
    localparam int TW_IDX_W = 7;

    typedef logic [DATA_W-1:0] coeff_t;

    localparam coeff_t Q = 28'd268369921;

    function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) begin
            s = s - {1'b0, Q};
        end
        return s[DATA_W-1:0];
    endfunction

    // For a < b the 28-bit wrap of a - b + Q lands on the true value, which is already < Q.
    function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b);
        coeff_t d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = a - b + Q;
        end
        return d;
    endfunction
endpackage

// File: rtl/mod_half.sv
// Registered multiply-by-1/2 mod q; only built with GS_BUTTERFLY_SCALE_HALF_EN defined.
`ifdef GS_BUTTERFLY_SCALE_HALF_EN
module mod_half
    import ntt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] i_v,
    output logic [27:0] o_v
);
    logic [27:0] r_v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v <= '0;
        end else if (i_v[0]) begin
            r_v <= 28'(({1'b0, i_v} + {1'b0, Q}) >> 1);
        end else begin
            r_v <= i_v >> 1;
        end
    end

    assign o_v = r_v;
endmodule
`endif

// File: rtl/modular_mult.sv
// Five-stage modular multiplier mod q: full product, three Solinas folds, final conditional subtract.
module modular_mult
    import ntt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] i_a,
    input  logic [27:0] i_b,
    output logic [27:0] o_p
);
    logic [55:0] r_p1;
    logic [44:0] r_p2;
    logic [33:0] r_p3;
    logic [28:0] r_p4;
    logic [27:0] r_p5;

    logic [27:0] w_h1;
    logic [16:0] w_h2;
    logic [5:0]  w_h3;

    // 2^28 == 2^16 - 1 (mod q), so each fold replaces the high part H by H*2^16 - H.
    assign w_h1 = r_p1[55:28];
    assign w_h2 = r_p2[44:28];
    assign w_h3 = r_p3[33:28];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p1 <= '0;
            r_p2 <= '0;
            r_p3 <= '0;
            r_p4 <= '0;
            r_p5 <= '0;
        end else begin
            r_p1 <= {28'd0, i_a} * {28'd0, i_b};
            r_p2 <= {1'b0, w_h1, 16'd0} - {17'd0, w_h1} + {17'd0, r_p1[27:0]};
            r_p3 <= {1'b0, w_h2, 16'd0} - {17'd0, w_h2} + {6'd0, r_p2[27:0]};
            r_p4 <= {7'd0, w_h3, 16'd0} - {23'd0, w_h3} + {1'b0, r_p3[27:0]};
            // r_p4 < 2^28 + 2^22 < 2q, one subtraction is enough
            r_p5 <= (r_p4 >= {1'b0, Q}) ? 28'(r_p4 - {1'b0, Q}) : r_p4[27:0];
        end
    end

    assign o_p = r_p5;
endmodule

// File: rtl/gs_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly mod q with internally sequenced twiddle index.
// GS_BUTTERFLY_SCALE_HALF_EN adds a halving stage on both outputs (latency 9 instead of 8).
module gs_butterfly
    import ntt_pkg::*;
#(
    parameter logic [8:0] START              = 9'd0,
    parameter coeff_t     FACTORS [TW_DEPTH] = '{default: 28'd1}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [27:0] x_in,
    input  logic [27:0] y_in,
    output logic        out_valid,
    output logic [27:0] x_out,
    output logic [27:0] y_out
);
`ifdef GS_BUTTERFLY_SCALE_HALF_EN
    localparam int LAT = MULT_LAT + 4;
`else
    localparam int LAT = MULT_LAT + 3;
`endif
    localparam int OUT_STG = MULT_LAT + 2;

    logic [8:0]          r_beat_cnt;
    logic [TW_IDX_W-1:0] r_index;
    coeff_t              r_sum;
    coeff_t              r_diff;
    coeff_t              r_w;
    coeff_t              r_sum_dly [MULT_LAT];
    coeff_t              r_sum_p;
    coeff_t              r_prod;
    coeff_t              r_x_o;
    coeff_t              r_y_o;
    logic [LAT-1:0]      r_vld;
    coeff_t              w_prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_index    <= '0;
            r_sum      <= '0;
            r_diff     <= '0;
            r_w        <= '0;
            for (int i = 0; i < MULT_LAT; i++) begin
                r_sum_dly[i] <= '0;
            end
            r_sum_p    <= '0;
            r_prod     <= '0;
            r_x_o      <= '0;
            r_y_o      <= '0;
            r_vld      <= '0;
        end else begin
            // Index stays at 0 until START beats have gone by, then steps once per beat.
            if (in_valid) begin
                if (r_beat_cnt < START) begin
                    r_beat_cnt <= r_beat_cnt + 9'd1;
                end else begin
                    r_index <= r_index + 1'b1;
                end
            end
            r_sum        <= mod_add(x_in, y_in);
            r_diff       <= mod_sub(x_in, y_in);
            r_w          <= FACTORS[r_index];
            r_sum_dly[0] <= r_sum;
            for (int i = 1; i < MULT_LAT; i++) begin
                r_sum_dly[i] <= r_sum_dly[i-1];
            end
            r_sum_p <= r_sum_dly[MULT_LAT-1];
            r_prod  <= w_prod;
            if (r_vld[OUT_STG-1]) begin
                r_x_o <= r_sum_p;
                r_y_o <= r_prod;
            end
            r_vld <= {r_vld[LAT-2:0], in_valid};
        end
    end

    modular_mult u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .i_a   (r_diff),
        .i_b   (r_w),
        .o_p   (w_prod)
    );

`ifdef GS_BUTTERFLY_SCALE_HALF_EN
    // Halving follows the held output register, so held values stay held.
    mod_half u_half_x (
        .clk   (clk),
        .rst_n (rst_n),
        .i_v   (r_x_o),
        .o_v   (x_out)
    );

    mod_half u_half_y (
        .clk   (clk),
        .rst_n (rst_n),
        .i_v   (r_y_o),
        .o_v   (y_out)
    );
`else
    assign x_out = r_x_o;
    assign y_out = r_y_o;
`endif

    assign out_valid = r_vld[LAT-1];
endmodule

// File: tb/tb_gs_butterfly.sv
// Randomized self-checking bench for gs_butterfly against a plain-arithmetic reference model.
module tb_gs_butterfly;
    import ntt_pkg::*;

`ifdef GS_BUTTERFLY_SCALE_HALF_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif
    localparam longint QL      = 268369921;
    localparam int     START_B = 2;
    localparam coeff_t TW_B [TW_DEPTH] = '{0: 28'd2, 1: 28'd3, 2: 28'd4, 3: 28'd5, 4: 28'd6,
                                          126: 28'd1000, 127: 28'd268369920,
                                          default: 28'd123456789};

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [27:0] x_in;
    logic [27:0] y_in;
    logic        ov_a, ov_b;
    logic [27:0] xo_a, yo_a, xo_b, yo_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit     v;
        longint xa, ya, xb, yb;
    } exp_t;

    exp_t   pipe [$];
    int     k;
    bit     ev;
    longint exa, eya, exb, eyb;

    gs_butterfly dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (ov_a),
        .x_out     (xo_a),
        .y_out     (yo_a)
    );

    gs_butterfly #(.START(9'(START_B)), .FACTORS(TW_B)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (ov_b),
        .x_out     (xo_b),
        .y_out     (yo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint scale(input longint v);
`ifdef GS_BUTTERFLY_SCALE_HALF_EN
        return (v % 2 == 0) ? v / 2 : (v + QL) / 2;
`else
        return v;
`endif
    endfunction

    function automatic longint rnd_coeff();
        case ($urandom_range(7, 0))
            0:       return 0;
            1:       return QL - 1;
            default: return longint'($urandom_range(268369920, 0));
        endcase
    endfunction

    task automatic apply_reset(input int n);
        rst_n = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pipe.delete();
        k = 0; ev = 0; exa = 0; eya = 0; exb = 0; eyb = 0;
    endtask

    // Drive one cycle and advance the model; expected outputs land in ev/exa/eya/exb/eyb.
    task automatic cycle(input bit v, input longint x, input longint y);
        exp_t   e;
        longint d;
        int     ib;
        in_valid = v; x_in = 28'(x); y_in = 28'(y);
        e.v = v; e.xa = 0; e.ya = 0; e.xb = 0; e.yb = 0;
        if (v) begin
            d    = (x - y + QL) % QL;
            ib   = (k <= START_B) ? 0 : (k - START_B) % TW_DEPTH;
            e.xa = scale((x + y) % QL);
            e.ya = scale(d);
            e.xb = e.xa;
            e.yb = scale((d * longint'(TW_B[ib])) % QL);
            k++;
        end
        pipe.push_back(e);
        @(posedge clk); #1;
        ev = 0;
        if (pipe.size() == LAT) begin
            e  = pipe.pop_front();
            ev = e.v;
            if (e.v) begin
                exa = e.xa; eya = e.ya; exb = e.xb; eyb = e.yb;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset(2);
        total++; if (ov_a !== 1'b0 || ov_b !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b%b want 00", ov_a, ov_b); end
        total++; if (xo_a !== 28'd0 || yo_a !== 28'd0) begin bad++; $display("FAIL reset_out_a: got %0d/%0d want 0/0", xo_a, yo_a); end
        total++; if (xo_b !== 28'd0 || yo_b !== 28'd0) begin bad++; $display("FAIL reset_out_b: got %0d/%0d want 0/0", xo_b, yo_b); end
    endtask

    task automatic test_basic();
        int lat;
        apply_reset(1);
        cycle(1, 5, 3);
        lat = 1;
        while (ov_a !== 1'b1 && lat < 4 * LAT) begin
            total++; if (ov_a !== ev) begin bad++; $display("FAIL basic_valid: got %b want %b", ov_a, ev); end
            cycle(0, 0, 0);
            lat++;
        end
        total++; if (lat != LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        total++; if (xo_a !== 28'(scale(8))) begin bad++; $display("FAIL basic_x: got %0d want %0d", xo_a, scale(8)); end
        total++; if (yo_a !== 28'(scale(2))) begin bad++; $display("FAIL basic_y: got %0d want %0d", yo_a, scale(2)); end
    endtask

    task automatic test_wrap();
        logic [27:0] gx [4];
        logic [27:0] gy [4];
        int n = 0;
        for (int c = 0; c < 3 + LAT + 1; c++) begin
            case (c)
                0:       cycle(1, QL - 1, 2);
                1:       cycle(1, 1, 3);
                2:       cycle(1, 2, 1);
                default: cycle(0, 0, 0);
            endcase
            total++; if (ov_a !== ev) begin bad++; $display("FAIL wrap_valid: cyc %0d got %b want %b", c, ov_a, ev); end
            if (ov_a === 1'b1 && n < 4) begin gx[n] = xo_a; gy[n] = yo_a; n++; end
        end
        total++; if (n != 3) begin bad++; $display("FAIL wrap_count: got %0d want 3", n); end
        else begin
            total++; if (gx[0] !== 28'(scale(1))) begin bad++; $display("FAIL wrap_x0: got %0d want %0d", gx[0], scale(1)); end
            total++; if (gy[0] !== 28'(scale(268369918))) begin bad++; $display("FAIL wrap_y0: got %0d want %0d", gy[0], scale(268369918)); end
            total++; if (gy[1] !== 28'(scale(268369919))) begin bad++; $display("FAIL wrap_y1: got %0d want %0d", gy[1], scale(268369919)); end
            total++; if (gx[2] !== 28'(scale(3)) || gy[2] !== 28'(scale(1))) begin bad++; $display("FAIL wrap_xy2: got %0d/%0d want %0d/%0d", gx[2], gy[2], scale(3), scale(1)); end
        end
    endtask

    // Five beats with diff = 1 through dut_b, separated by `gap` idle cycles.
    task automatic run_twiddle_seq(input int gap, input string tag);
        longint      want [5];
        logic [27:0] got [8];
        int n = 0;
        want = '{scale(2), scale(2), scale(2), scale(3), scale(4)};
        apply_reset(1);
        for (int b = 0; b < 5; b++) begin
            for (int g = 0; g <= gap; g++) begin
                if (g == 0) cycle(1, 0, QL - 1);
                else        cycle(0, 0, 0);
                total++; if (ov_b !== ev) begin bad++; $display("FAIL %s_valid: beat %0d got %b want %b", tag, b, ov_b, ev); end
                if (ov_b === 1'b1 && n < 8) begin got[n] = yo_b; n++; end
            end
        end
        for (int c = 0; c < LAT + 1; c++) begin
            cycle(0, 0, 0);
            total++; if (ov_b !== ev) begin bad++; $display("FAIL %s_valid: drain %0d got %b want %b", tag, c, ov_b, ev); end
            if (ov_b === 1'b1 && n < 8) begin got[n] = yo_b; n++; end
        end
        total++; if (n != 5) begin bad++; $display("FAIL %s_count: got %0d want 5", tag, n); end
        else begin
            for (int i = 0; i < 5; i++) begin
                total++; if (got[i] !== 28'(want[i])) begin bad++; $display("FAIL %s_y%0d: got %0d want %0d", tag, i, got[i], want[i]); end
            end
        end
    endtask

    task automatic test_twiddle_seq();
        run_twiddle_seq(0, "tw_b2b");
    endtask

    task automatic test_gaps();
        run_twiddle_seq(3, "tw_gap");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [27:0] gy;
        for (int b = 0; b < 4; b++) cycle(1, rnd_coeff(), rnd_coeff());
        apply_reset(1);
        total++; if (ov_a !== 1'b0 || ov_b !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b%b want 00", ov_a, ov_b); end
        total++; if (xo_a !== 28'd0 || yo_a !== 28'd0 || xo_b !== 28'd0 || yo_b !== 28'd0) begin
            bad++; $display("FAIL rmid_out: got %0d/%0d/%0d/%0d want 0", xo_a, yo_a, xo_b, yo_b);
        end
        gy = '0;
        for (int c = 0; c < LAT + 4; c++) begin
            if (c == 3) cycle(1, 0, QL - 1);
            else        cycle(0, 0, 0);
            total++; if (ov_a !== ev || ov_b !== ev) begin bad++; $display("FAIL rmid_stale: cyc %0d got %b%b want %b", c, ov_a, ov_b, ev); end
            if (ov_b === 1'b1) begin gy = yo_b; n++; end
        end
        total++; if (n != 1 || gy !== 28'(scale(longint'(TW_B[0])))) begin
            bad++; $display("FAIL rmid_factor0: got %0d outputs y=%0d want 1 y=%0d", n, gy, scale(longint'(TW_B[0])));
        end
    endtask

    task automatic test_random();
        apply_reset(1);
        for (int c = 0; c < 400 + LAT; c++) begin
            if (c < 400) cycle($urandom_range(3, 0) != 0, rnd_coeff(), rnd_coeff());
            else         cycle(0, 0, 0);
            total++; if (ov_a !== ev || ov_b !== ev) begin bad++; $display("FAIL rand_valid: cyc %0d got %b%b want %b", c, ov_a, ov_b, ev); end
            total++; if (xo_a !== 28'(exa) || yo_a !== 28'(eya)) begin bad++; $display("FAIL rand_a: cyc %0d got %0d/%0d want %0d/%0d", c, xo_a, yo_a, exa, eya); end
            total++; if (xo_b !== 28'(exb) || yo_b !== 28'(eyb)) begin bad++; $display("FAIL rand_b: cyc %0d got %0d/%0d want %0d/%0d", c, xo_b, yo_b, exb, eyb); end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_twiddle_seq();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
